// File: rtl/reg_serial_ctrl_pkg.sv
// Shared definitions for the serial register-bank controller.
//   DATA_W   : width of one config register / serial transfer
//   BITCNT_W : width of the serial bit counter
//   state_t  : controller FSM states
package reg_serial_ctrl_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BITCNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WSHIFT = 3'd1,
        ST_WLATCH = 3'd2,
        ST_RLATCH = 3'd3,
        ST_RSHIFT = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/reg_serial_ctrl_serdes.sv
// 32-bit data shift register with bit counter for the serial transfer.
// Ports:
//   bclk, rst    : clock, synchronous active-high reset
//   i_load       : load i_load_data into the shift register, clear counter
//   i_load_data  : parallel load value
//   i_shift      : shift left one bit, i_bit enters at the LSB, counter++
//   i_bit        : serial bit shifted in
//   o_dsr        : current shift register contents
//   o_last_c     : counter is at the final bit of a transfer
module reg_serial_ctrl_serdes
    import reg_serial_ctrl_pkg::*;
(
    input  logic              bclk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_shift,
    input  logic              i_bit,
    output logic [DATA_W-1:0] o_dsr,
    output logic              o_last_c
);

    logic [DATA_W-1:0]   r_dsr;
    logic [BITCNT_W-1:0] r_cnt;

    // Load has priority over shift; the counter restarts on every load.
    always_ff @(posedge bclk) begin
        if (rst) begin
            r_dsr <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_dsr <= i_load_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_dsr <= {r_dsr[DATA_W-2:0], i_bit};
            r_cnt <= r_cnt + BITCNT_W'(1);
        end
    end

    assign o_dsr    = r_dsr;
    assign o_last_c = (r_cnt == BITCNT_W'(DATA_W - 1));

endmodule

// File: rtl/reg_serial_ctrl.sv
// Serial access controller for a bank of triplicated 32-bit config registers.
// Turns one parallel read/write command into a 32-bit MSB-first serial transfer
// plus a latch strobe, and keeps a sticky soft-error flag.
// Ports:
//   bclk, rst                  : clock, synchronous active-high reset
//   cmdValid/cmdReady          : command handshake (accepted when both high at posedge)
//   cmdWrite/cmdAddr/cmdData   : command type, target slice, write data
//   shiftEn/latchIn/latchOut   : one-hot per-slice strobes
//   shiftIn / shiftOut         : shared serial data out / per-slice serial data in
//   rdValid/rdData/rdErr       : read completion pulse, result, out-of-range flag
//   wrErr                      : pulse for an out-of-range write
//   serIn/clrSer/serErr        : soft-error chain input, clear, sticky flag
module reg_serial_ctrl
    import reg_serial_ctrl_pkg::*;
#(
    parameter int unsigned N_REG  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              bclk,
    input  logic              rst,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic              cmdWrite,
    input  logic [ADDR_W-1:0] cmdAddr,
    input  logic [DATA_W-1:0] cmdData,
    output logic [N_REG-1:0]  shiftEn,
    output logic [N_REG-1:0]  latchIn,
    output logic [N_REG-1:0]  latchOut,
    output logic              shiftIn,
    input  logic [N_REG-1:0]  shiftOut,
    output logic              rdValid,
    output logic [DATA_W-1:0] rdData,
    output logic              rdErr,
    output logic              wrErr,
    input  logic              serIn,
    input  logic              clrSer,
    output logic              serErr
);

    state_t            r_state;
    logic              r_cmd_ready;
    logic [N_REG-1:0]  r_sel;
    logic [N_REG-1:0]  r_shift_en;
    logic [N_REG-1:0]  r_latch_in;
    logic [N_REG-1:0]  r_latch_out;
    logic              r_shift_in;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_err;
    logic              r_wr_err;
    logic              r_ser_err;

    logic [N_REG-1:0]  w_dec;
    logic              w_in_range;
    logic              w_accept;
    logic              w_sout;
    logic              w_load;
    logic [DATA_W-1:0] w_load_data;
    logic              w_shift;
    logic              w_ser_bit;
    logic [DATA_W-1:0] w_dsr;
    logic              w_last;

    // One-hot address decode; an address with no matching slice decodes to zero.
    always_comb begin
        w_dec = '0;
        for (int unsigned i = 0; i < N_REG; i++) begin
            w_dec[i] = (cmdAddr == ADDR_W'(i));
        end
    end

    assign w_in_range = |w_dec;
    assign w_accept   = cmdValid & r_cmd_ready;
    assign w_sout     = |(shiftOut & r_sel);

    // Write data is loaded pre-shifted: its MSB leaves via shiftIn on the accept edge.
    assign w_load      = w_accept & w_in_range;
    assign w_load_data = cmdWrite ? {cmdData[DATA_W-2:0], 1'b0} : '0;
    assign w_shift     = (r_state == ST_WSHIFT) | (r_state == ST_RSHIFT);
    assign w_ser_bit   = (r_state == ST_RSHIFT) ? w_sout : 1'b0;

    reg_serial_ctrl_serdes u_serdes (
        .bclk        (bclk),
        .rst         (rst),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_shift     (w_shift),
        .i_bit       (w_ser_bit),
        .o_dsr       (w_dsr),
        .o_last_c    (w_last)
    );

    // Controller FSM; every strobe is registered alongside the state it belongs to.
    always_ff @(posedge bclk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cmd_ready <= 1'b1;
            r_sel       <= '0;
            r_shift_en  <= '0;
            r_latch_in  <= '0;
            r_latch_out <= '0;
            r_shift_in  <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_err    <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_wr_err   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sel <= w_dec;
                        if (!w_in_range) begin
                            // Out-of-range: no strobes, report and finish at once.
                            if (cmdWrite) begin
                                r_wr_err <= 1'b1;
                            end else begin
                                r_state     <= ST_DONE;
                                r_cmd_ready <= 1'b0;
                                r_rd_valid  <= 1'b1;
                                r_rd_data   <= '0;
                                r_rd_err    <= 1'b1;
                            end
                        end else if (cmdWrite) begin
                            r_state     <= ST_WSHIFT;
                            r_cmd_ready <= 1'b0;
                            r_shift_en  <= w_dec;
                            r_shift_in  <= cmdData[DATA_W-1];
                        end else begin
                            r_state     <= ST_RLATCH;
                            r_cmd_ready <= 1'b0;
                            r_latch_out <= w_dec;
                        end
                    end
                end
                ST_WSHIFT: begin
                    if (w_last) begin
                        r_state    <= ST_WLATCH;
                        r_shift_en <= '0;
                        r_shift_in <= 1'b0;
                        r_latch_in <= r_sel;
                    end else begin
                        r_shift_in <= w_dsr[DATA_W-1];
                    end
                end
                ST_WLATCH: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_latch_in  <= '0;
                end
                ST_RLATCH: begin
                    r_state     <= ST_RSHIFT;
                    r_latch_out <= '0;
                    r_shift_en  <= r_sel;
                end
                ST_RSHIFT: begin
                    // Final captured bit goes straight into the result register.
                    if (w_last) begin
                        r_state    <= ST_DONE;
                        r_shift_en <= '0;
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= {w_dsr[DATA_W-2:0], w_sout};
                        r_rd_err   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_shift_en  <= '0;
                    r_latch_in  <= '0;
                    r_latch_out <= '0;
                    r_shift_in  <= 1'b0;
                end
            endcase
        end
    end

    // Sticky soft-error flag; a new error outranks a clear in the same cycle.
    always_ff @(posedge bclk) begin
        if (rst) begin
            r_ser_err <= 1'b0;
        end else if (serIn) begin
            r_ser_err <= 1'b1;
        end else if (clrSer) begin
            r_ser_err <= 1'b0;
        end
    end

    assign cmdReady = r_cmd_ready;
    assign shiftEn  = r_shift_en;
    assign latchIn  = r_latch_in;
    assign latchOut = r_latch_out;
    assign shiftIn  = r_shift_in;
    assign rdValid  = r_rd_valid;
    assign rdData   = r_rd_data;
    assign rdErr    = r_rd_err;
    assign wrErr    = r_wr_err;
    assign serErr   = r_ser_err;

endmodule

// File: tb/tb_reg_serial_ctrl.sv
module tb_reg_serial_ctrl;

    localparam int unsigned NR = 48;

    logic          bclk = 1'b0;
    logic          rst;
    logic          cmdValid;
    logic          cmdReady;
    logic          cmdWrite;
    logic [5:0]    cmdAddr;
    logic [31:0]   cmdData;
    logic [NR-1:0] shiftEn;
    logic [NR-1:0] latchIn;
    logic [NR-1:0] latchOut;
    logic          shiftIn;
    logic [NR-1:0] shiftOut;
    logic          rdValid;
    logic [31:0]   rdData;
    logic          rdErr;
    logic          wrErr;
    logic          serIn;
    logic          clrSer;
    logic          serErr;

    always #5 bclk = ~bclk;

    reg_serial_ctrl #(.N_REG(NR), .ADDR_W(6)) dut (
        .bclk     (bclk),
        .rst      (rst),
        .cmdValid (cmdValid),
        .cmdReady (cmdReady),
        .cmdWrite (cmdWrite),
        .cmdAddr  (cmdAddr),
        .cmdData  (cmdData),
        .shiftEn  (shiftEn),
        .latchIn  (latchIn),
        .latchOut (latchOut),
        .shiftIn  (shiftIn),
        .shiftOut (shiftOut),
        .rdValid  (rdValid),
        .rdData   (rdData),
        .rdErr    (rdErr),
        .wrErr    (wrErr),
        .serIn    (serIn),
        .clrSer   (clrSer),
        .serErr   (serErr)
    );

    // Slices: a state register and a shifter each, independent of the controller reset.
    logic [31:0] sl_state [NR];
    logic [31:0] sl_shf   [NR];

    always @(posedge bclk) begin
        for (int i = 0; i < NR; i++) begin
            if (latchOut[i])      sl_shf[i] <= sl_state[i];
            else if (shiftEn[i])  sl_shf[i] <= {sl_shf[i][30:0], shiftIn};
            if (latchIn[i])       sl_state[i] <= sl_shf[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NR; i++) shiftOut[i] = shiftEn[i] & sl_shf[i][31];
    end

    // Reference: contents the bank should hold, and the last completed read result.
    logic [31:0] mem [NR];
    logic [31:0] last_rd;
    int checks = 0;
    int errors = 0;

    // Per-command trace, cycle numbers counted from the accepting edge.
    int t_rdy, t_rdv, n_rdv, t_wre, n_wre, n_se, se_first, se_last, n_li, t_li, n_lo, t_lo, viol;
    logic [31:0] sin_bits, rd_cap;
    logic        rerr_cap;

    typedef struct {
        logic        w;
        logic [5:0]  a;
        logic [31:0] d;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string tag, input string what, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s got=%0h want=%0h", tag, what, act, exp);
        end
    endtask

    function automatic logic [NR-1:0] sel_of(input logic [5:0] a);
        logic [NR-1:0] s;
        for (int i = 0; i < NR; i++) s[i] = (a == 6'(i));
        return s;
    endfunction

    task automatic wait_ready(input string tag);
        int g;
        g = 0;
        while (!cmdReady && g < 100) begin
            @(negedge bclk);
            g++;
        end
        chk(tag, "ready_wait", 64'(cmdReady), 64'd1);
    endtask

    // Issue one command and record what the strobes/outputs did on each following cycle.
    task automatic run_cmd(input string tag, input logic w, input logic [5:0] a, input logic [31:0] d, input bit noise);
        logic [NR-1:0] sel;
        sel = sel_of(a);
        @(negedge bclk);
        wait_ready(tag);
        cmdValid = 1'b1; cmdWrite = w; cmdAddr = a; cmdData = d;
        @(posedge bclk);
        t_rdy = -1; t_rdv = -1; n_rdv = 0; t_wre = -1; n_wre = 0; n_se = 0; se_first = -1; se_last = -1;
        n_li = 0; t_li = -1; n_lo = 0; t_lo = -1; viol = 0; sin_bits = '0; rd_cap = 'x; rerr_cap = 1'bx;
        for (int k = 1; k <= 60; k++) begin
            @(negedge bclk);
            if (rdValid) begin n_rdv++; t_rdv = k; rd_cap = rdData; rerr_cap = rdErr; end
            if (wrErr) begin n_wre++; t_wre = k; end
            if (shiftEn != '0) begin
                n_se++;
                if (se_first < 0) se_first = k;
                se_last = k;
                if (shiftEn != sel) viol++;
                if (w) sin_bits = {sin_bits[30:0], shiftIn};
                else if (shiftIn) viol++;
            end
            if (latchIn != '0) begin
                n_li++; t_li = k;
                if (latchIn != sel || shiftEn != '0) viol++;
            end
            if (latchOut != '0) begin
                n_lo++; t_lo = k;
                if (latchOut != sel || shiftEn != '0) viol++;
            end
            if (cmdReady) begin
                t_rdy = k;
                cmdValid = 1'b0;
                break;
            end
            if (noise) begin
                cmdValid = 1'($urandom_range(0, 1));
                cmdWrite = 1'($urandom_range(0, 1));
                cmdAddr  = 6'($urandom_range(0, 63));
                cmdData  = $urandom;
            end else begin
                cmdValid = 1'b0;
            end
        end
    endtask

    task automatic check_cmd(input string tag, input logic w, input logic [5:0] a, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic exp_err, input bit noise);
        int strobes;
        run_cmd(tag, w, a, d, noise);
        strobes = n_se + n_li + n_lo;
        if (w && !exp_err) begin
            chk(tag, "ready_cyc", 64'(t_rdy), 64'd34);
            chk(tag, "se_count", 64'(n_se), 64'd32);
            chk(tag, "se_first", 64'(se_first), 64'd1);
            chk(tag, "se_last", 64'(se_last), 64'd32);
            chk(tag, "shiftin_bits", 64'(sin_bits), 64'(d));
            chk(tag, "latchin_count", 64'(n_li), 64'd1);
            chk(tag, "latchin_cyc", 64'(t_li), 64'd33);
            chk(tag, "latchout_count", 64'(n_lo), 64'd0);
            chk(tag, "rdvalid_count", 64'(n_rdv), 64'd0);
            chk(tag, "wrerr_count", 64'(n_wre), 64'd0);
            mem[a] = d;
        end else if (w) begin
            chk(tag, "ready_cyc", 64'(t_rdy), 64'd1);
            chk(tag, "wrerr_count", 64'(n_wre), 64'd1);
            chk(tag, "wrerr_cyc", 64'(t_wre), 64'd1);
            chk(tag, "strobes", 64'(strobes), 64'd0);
            chk(tag, "rdvalid_count", 64'(n_rdv), 64'd0);
        end else if (!exp_err) begin
            chk(tag, "ready_cyc", 64'(t_rdy), 64'd35);
            chk(tag, "latchout_count", 64'(n_lo), 64'd1);
            chk(tag, "latchout_cyc", 64'(t_lo), 64'd1);
            chk(tag, "se_count", 64'(n_se), 64'd32);
            chk(tag, "se_first", 64'(se_first), 64'd2);
            chk(tag, "se_last", 64'(se_last), 64'd33);
            chk(tag, "latchin_count", 64'(n_li), 64'd0);
            chk(tag, "rdvalid_count", 64'(n_rdv), 64'd1);
            chk(tag, "rdvalid_cyc", 64'(t_rdv), 64'd34);
            chk(tag, "rd_data", 64'(rd_cap), 64'(exp_rd));
            chk(tag, "rd_err", 64'(rerr_cap), 64'd0);
            chk(tag, "wrerr_count", 64'(n_wre), 64'd0);
            last_rd = exp_rd;
        end else begin
            chk(tag, "ready_cyc", 64'(t_rdy), 64'd2);
            chk(tag, "strobes", 64'(strobes), 64'd0);
            chk(tag, "rdvalid_count", 64'(n_rdv), 64'd1);
            chk(tag, "rdvalid_cyc", 64'(t_rdv), 64'd1);
            chk(tag, "rd_data", 64'(rd_cap), 64'(exp_rd));
            chk(tag, "rd_err", 64'(rerr_cap), 64'd1);
            chk(tag, "wrerr_count", 64'(n_wre), 64'd0);
            last_rd = 32'h0;
        end
        chk(tag, "strobe_rules", 64'(viol), 64'd0);
        chk(tag, "rd_hold", 64'(rdData), 64'(last_rd));
    endtask

    initial begin
        logic [NR-1:0] li33, se33, se_acc;
        int acc, n;

        rst = 1'b1; cmdValid = 1'b0; cmdWrite = 1'b0; cmdAddr = '0; cmdData = '0;
        serIn = 1'b0; clrSer = 1'b0;
        for (int i = 0; i < NR; i++) begin
            sl_state[i] = 32'h0; sl_shf[i] = 32'h0; mem[i] = 32'h0;
        end
        last_rd = 32'h0;

        tbl[0]  = '{1'b1, 6'd3,  32'hA5C30F81, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 6'd3,  32'h0,        32'hA5C30F81, 1'b0};
        tbl[2]  = '{1'b1, 6'd47, 32'h00000001, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 6'd47, 32'h0,        32'h00000001, 1'b0};
        tbl[4]  = '{1'b1, 6'd0,  32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 6'd0,  32'h0,        32'hFFFFFFFF, 1'b0};
        tbl[6]  = '{1'b1, 6'd50, 32'hDEADBEEF, 32'h0,        1'b1};
        tbl[7]  = '{1'b0, 6'd50, 32'h0,        32'h0,        1'b1};
        tbl[8]  = '{1'b1, 6'd48, 32'h12345678, 32'h0,        1'b1};
        tbl[9]  = '{1'b0, 6'd63, 32'h0,        32'h0,        1'b1};
        tbl[10] = '{1'b0, 6'd3,  32'h0,        32'hA5C30F81, 1'b0};

        repeat (3) @(negedge bclk);
        rst = 1'b0;
        @(negedge bclk);
        chk("reset", "cmdReady", 64'(cmdReady), 64'd1);
        chk("reset", "strobes", 64'(shiftEn | latchIn | latchOut), 64'd0);
        chk("reset", "shiftIn", 64'(shiftIn), 64'd0);
        chk("reset", "rdValid", 64'(rdValid), 64'd0);
        chk("reset", "rdData", 64'(rdData), 64'd0);
        chk("reset", "rdErr_wrErr", 64'({rdErr, wrErr}), 64'd0);
        chk("reset", "serErr", 64'(serErr), 64'd0);

        for (int i = 0; i < 11; i++) begin
            check_cmd($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp_rd, tbl[i].exp_err, 1'b0);
        end
        chk("vec", "slice3_state", 64'(sl_state[3]), 64'hA5C30F81);

        // Reset in the middle of a write: no latch, slice keeps its old value.
        @(negedge bclk);
        wait_ready("rst_mid");
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 6'd3; cmdData = 32'h13579BDF;
        @(posedge bclk);
        @(negedge bclk);
        cmdValid = 1'b0;
        repeat (9) @(negedge bclk);
        chk("rst_mid", "shifting", 64'(shiftEn), 64'(sel_of(6'd3)));
        rst = 1'b1;
        @(negedge bclk);
        chk("rst_mid", "strobes", 64'(shiftEn | latchIn | latchOut), 64'd0);
        chk("rst_mid", "cmdReady", 64'(cmdReady), 64'd1);
        rst = 1'b0;
        n = 0;
        repeat (40) begin
            @(negedge bclk);
            if (latchIn != '0 || shiftEn != '0) n++;
        end
        chk("rst_mid", "strobes_after", 64'(n), 64'd0);
        chk("rst_mid", "slice3_kept", 64'(sl_state[3]), 64'(mem[3]));
        chk("rst_mid", "cmdReady_after", 64'(cmdReady), 64'd1);
        last_rd = 32'h0;
        chk("rst_mid", "rdData_cleared", 64'(rdData), 64'd0);
        check_cmd("rst_rd", 1'b0, 6'd3, 32'h0, mem[3], 1'b0, 1'b0);

        // Two writes with cmdValid held high throughout.
        @(negedge bclk);
        wait_ready("b2b");
        cmdValid = 1'b1; cmdWrite = 1'b1; cmdAddr = 6'd10; cmdData = 32'h0F0F1234;
        @(posedge bclk);
        acc = -1; li33 = '0; se33 = '1; se_acc = '1;
        for (int k = 1; k <= 60; k++) begin
            @(negedge bclk);
            if (k == 33) begin li33 = latchIn; se33 = shiftEn; end
            if (cmdReady) begin acc = k; se_acc = shiftEn; break; end
            cmdAddr = 6'd11; cmdData = 32'hC001D00D;
        end
        chk("b2b", "accept_cyc", 64'(acc), 64'd34);
        chk("b2b", "latchin_33", 64'(li33), 64'(sel_of(6'd10)));
        chk("b2b", "shiften_33", 64'(se33), 64'd0);
        chk("b2b", "shiften_34", 64'(se_acc), 64'd0);
        @(posedge bclk);
        @(negedge bclk);
        cmdValid = 1'b0;
        chk("b2b", "second_shift", 64'(shiftEn), 64'(sel_of(6'd11)));
        wait_ready("b2b_end");
        mem[10] = 32'h0F0F1234;
        mem[11] = 32'hC001D00D;
        check_cmd("b2b_rd10", 1'b0, 6'd10, 32'h0, mem[10], 1'b0, 1'b0);
        check_cmd("b2b_rd11", 1'b0, 6'd11, 32'h0, mem[11], 1'b0, 1'b0);

        // Sticky soft-error flag.
        @(negedge bclk);
        serIn = 1'b1;
        @(negedge bclk);
        serIn = 1'b0;
        chk("ser", "set", 64'(serErr), 64'd1);
        @(negedge bclk);
        chk("ser", "sticky", 64'(serErr), 64'd1);
        clrSer = 1'b1;
        @(negedge bclk);
        clrSer = 1'b0;
        chk("ser", "cleared", 64'(serErr), 64'd0);
        serIn = 1'b1; clrSer = 1'b1;
        @(negedge bclk);
        serIn = 1'b0; clrSer = 1'b0;
        chk("ser", "set_wins", 64'(serErr), 64'd1);
        @(negedge bclk);
        chk("ser", "held", 64'(serErr), 64'd1);

        // Random commands with junk requests while busy, against the bank model.
        for (int n2 = 0; n2 < 40; n2++) begin
            logic        rw;
            logic [5:0]  ra;
            logic [31:0] rdv;
            rw  = 1'($urandom_range(0, 1));
            ra  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(40, 63)) : 6'($urandom_range(0, 5));
            rdv = $urandom;
            if (ra < 6'd48) check_cmd("rand", rw, ra, rdv, rw ? 32'h0 : mem[ra], 1'b0, 1'b1);
            else            check_cmd("rand", rw, ra, rdv, 32'h0, 1'b1, 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            check_cmd("final_rd", 1'b0, 6'(i), 32'h0, mem[i], 1'b0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
